// File: rtl/time_set_ctrl_pkg.sv
// time_set_ctrl_pkg
//   Shared definitions for the front-panel time-setting sequencer:
//   FSM state encodings, field_sel codes, BCD limits, the packed BCD time
//   record and the clamp-on-load helper.
package time_set_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_EDIT_HR  = 3'd2,
    ST_EDIT_MIN = 3'd3,
    ST_EDIT_SEC = 3'd4,
    ST_COMMIT   = 3'd5
  } state_t;

  localparam logic [1:0] FS_NONE = 2'd0;
  localparam logic [1:0] FS_HR   = 2'd1;
  localparam logic [1:0] FS_MIN  = 2'd2;
  localparam logic [1:0] FS_SEC  = 2'd3;

  localparam logic [3:0] HR_MAX_T       = 4'd2;
  localparam logic [3:0] HR_MAX_O_AT_T2 = 4'd3;
  localparam logic [3:0] MS_MAX_T       = 4'd5;
  localparam logic [3:0] DIG_MAX        = 4'd9;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_o;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
  } bcd_pair_t;

  // Any out-of-range pair (bad digit, tens above limit, or ones above the
  // limit that applies when tens is at its maximum) loads as 00.
  function automatic bcd_pair_t clamp_pair(input bcd_pair_t p,
                                           input logic [3:0] max_t,
                                           input logic [3:0] max_o_top);
    bcd_pair_t r;
    r = p;
    if (p.t > max_t || p.o > DIG_MAX || (p.t == max_t && p.o > max_o_top))
      r = '0;
    return r;
  endfunction

  function automatic logic is_edit(input state_t s);
    return (s == ST_EDIT_HR) || (s == ST_EDIT_MIN) || (s == ST_EDIT_SEC);
  endfunction

endpackage

// File: rtl/time_set_ctrl_bcd_pair_step.sv
// time_set_ctrl_bcd_pair_step
//   Combinational +/-1 step of a two-digit BCD pair with wrap.
//   Ports:
//     i_tens, i_ones     current pair
//     i_inc, i_dec       step direction; both or neither = hold
//     i_max_t            tens value of the pair maximum
//     i_max_o_top        ones value of the pair maximum (23 -> 3, 59 -> 9)
//     o_tens, o_ones     next pair
module time_set_ctrl_bcd_pair_step
  import time_set_ctrl_pkg::*;
(
  input  logic [3:0] i_tens,
  input  logic [3:0] i_ones,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic [3:0] i_max_t,
  input  logic [3:0] i_max_o_top,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  always_comb begin
    o_tens = i_tens;
    o_ones = i_ones;
    if (i_inc && !i_dec) begin
      if (i_tens == i_max_t && i_ones == i_max_o_top) begin
        o_tens = 4'd0;
        o_ones = 4'd0;
      end else if (i_ones == DIG_MAX) begin
        o_tens = i_tens + 4'd1;
        o_ones = 4'd0;
      end else begin
        o_ones = i_ones + 4'd1;
      end
    end else if (i_dec && !i_inc) begin
      if (i_tens == 4'd0 && i_ones == 4'd0) begin
        o_tens = i_max_t;
        o_ones = i_max_o_top;
      end else if (i_ones == 4'd0) begin
        o_tens = i_tens - 4'd1;
        o_ones = DIG_MAX;
      end else begin
        o_ones = i_ones - 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl
//   Front-panel time-setting sequencer for the BCD clock unit. Turns
//   debounced button pulses into an hours/minutes/seconds edit session and
//   finishes with a flop-driven overwrite pulse into the clock unit.
//   Parameters:
//     OW_CYCLES   cycles time_ow stays high in COMMIT (>=1)
//     BLINK_HALF  clk cycles per blink half-period (>=2)
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     btn_mode/inc/dec/cancel         one-cycle button pulses
//     cur_{hr,min,sec}_{t,o}          live BCD time from the clock unit
//     set_{hr,min,sec}_{t,o}          shadow BCD time to the clock unit
//     time_ow                         registered overwrite strobe
//     set_active                      high outside IDLE
//     field_sel                       0 none, 1 hr, 2 min, 3 sec
//     blink                           blank strobe for the selected field
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int OW_CYCLES  = 2,
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_cancel,
  input  logic [3:0] cur_hr_t,
  input  logic [3:0] cur_hr_o,
  input  logic [3:0] cur_min_t,
  input  logic [3:0] cur_min_o,
  input  logic [3:0] cur_sec_t,
  input  logic [3:0] cur_sec_o,
  output logic [3:0] set_hr_t,
  output logic [3:0] set_hr_o,
  output logic [3:0] set_min_t,
  output logic [3:0] set_min_o,
  output logic [3:0] set_sec_t,
  output logic [3:0] set_sec_o,
  output logic       time_ow,
  output logic       set_active,
  output logic [1:0] field_sel,
  output logic       blink
);

  localparam int OW_W = (OW_CYCLES > 1) ? $clog2(OW_CYCLES + 1) : 1;
  localparam int BL_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  state_t            r_state;
  state_t            w_nxt;
  bcd_time_t         r_shadow;
  bcd_time_t         r_samp;
  bcd_time_t         w_cur;
  bcd_time_t         w_cur_clamped;
  logic [1:0]        r_cap_cnt;
  logic              w_cap_done;
  logic              w_step_req;
  logic [3:0]        w_sel_t;
  logic [3:0]        w_sel_o;
  logic [3:0]        w_max_t;
  logic [3:0]        w_max_o;
  logic [3:0]        w_nxt_t;
  logic [3:0]        w_nxt_o;
  logic              r_ow;
  logic [OW_W-1:0]   r_ow_cnt;
  logic              r_blink;
  logic [BL_W-1:0]   r_blink_cnt;
  logic              w_blink_clr;

  assign w_cur = {cur_hr_t, cur_hr_o, cur_min_t, cur_min_o, cur_sec_t, cur_sec_o};

  always_comb begin
    w_cur_clamped = w_cur;
    {w_cur_clamped.hr_t, w_cur_clamped.hr_o} =
      clamp_pair({w_cur.hr_t, w_cur.hr_o}, HR_MAX_T, HR_MAX_O_AT_T2);
    {w_cur_clamped.min_t, w_cur_clamped.min_o} =
      clamp_pair({w_cur.min_t, w_cur.min_o}, MS_MAX_T, DIG_MAX);
    {w_cur_clamped.sec_t, w_cur_clamped.sec_o} =
      clamp_pair({w_cur.sec_t, w_cur.sec_o}, MS_MAX_T, DIG_MAX);
  end

  // cur_* comes from the asynchronous 1 Hz domain: accept it once two
  // consecutive samples agree, or take whatever is present on the 4th cycle.
  assign w_cap_done = (r_state == ST_CAPTURE) &&
                      ((r_cap_cnt != 2'd0 && w_cur == r_samp) || r_cap_cnt == 2'd3);

  // Cancel and mode both outrank inc/dec in the same cycle.
  assign w_step_req = is_edit(r_state) && !btn_cancel && !btn_mode &&
                      (btn_inc || btn_dec);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (btn_mode && !btn_cancel) w_nxt = ST_CAPTURE;
      ST_CAPTURE:  if (btn_cancel) w_nxt = ST_IDLE;
                   else if (w_cap_done) w_nxt = ST_EDIT_HR;
      ST_EDIT_HR:  if (btn_cancel) w_nxt = ST_IDLE;
                   else if (btn_mode) w_nxt = ST_EDIT_MIN;
      ST_EDIT_MIN: if (btn_cancel) w_nxt = ST_IDLE;
                   else if (btn_mode) w_nxt = ST_EDIT_SEC;
      ST_EDIT_SEC: if (btn_cancel) w_nxt = ST_IDLE;
                   else if (btn_mode) w_nxt = ST_COMMIT;
      // Buttons are ignored here; the exit is purely counter driven.
      ST_COMMIT:   if (r_ow_cnt == OW_W'(OW_CYCLES)) w_nxt = ST_IDLE;
      default:     w_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    set_active = (r_state != ST_IDLE);
    field_sel  = FS_NONE;
    unique case (r_state)
      ST_EDIT_HR:  field_sel = FS_HR;
      ST_EDIT_MIN: field_sel = FS_MIN;
      ST_EDIT_SEC: field_sel = FS_SEC;
      default:     field_sel = FS_NONE;
    endcase
  end

  // ---------------- capture sampler ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp    <= '0;
      r_cap_cnt <= 2'd0;
    end else if (r_state == ST_CAPTURE) begin
      r_samp    <= w_cur;
      r_cap_cnt <= r_cap_cnt + 2'd1;
    end else begin
      r_cap_cnt <= 2'd0;
    end
  end

  // ---------------- field step (one stepper, muxed by field) ----------------
  always_comb begin
    w_sel_t = r_shadow.hr_t;
    w_sel_o = r_shadow.hr_o;
    w_max_t = HR_MAX_T;
    w_max_o = HR_MAX_O_AT_T2;
    unique case (r_state)
      ST_EDIT_MIN: begin
        w_sel_t = r_shadow.min_t;
        w_sel_o = r_shadow.min_o;
        w_max_t = MS_MAX_T;
        w_max_o = DIG_MAX;
      end
      ST_EDIT_SEC: begin
        w_sel_t = r_shadow.sec_t;
        w_sel_o = r_shadow.sec_o;
        w_max_t = MS_MAX_T;
        w_max_o = DIG_MAX;
      end
      default: ;
    endcase
  end

  time_set_ctrl_bcd_pair_step u_step (
    .i_tens      (w_sel_t),
    .i_ones      (w_sel_o),
    .i_inc       (btn_inc),
    .i_dec       (btn_dec),
    .i_max_t     (w_max_t),
    .i_max_o_top (w_max_o),
    .o_tens      (w_nxt_t),
    .o_ones      (w_nxt_o)
  );

  // ---------------- shadow registers ----------------
  // Written only on capture load or an accepted step, so they hold through
  // IDLE, COMMIT and after cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_cap_done && !btn_cancel) begin
      r_shadow <= w_cur_clamped;
    end else if (w_step_req) begin
      unique case (r_state)
        ST_EDIT_HR:  {r_shadow.hr_t,  r_shadow.hr_o}  <= {w_nxt_t, w_nxt_o};
        ST_EDIT_MIN: {r_shadow.min_t, r_shadow.min_o} <= {w_nxt_t, w_nxt_o};
        ST_EDIT_SEC: {r_shadow.sec_t, r_shadow.sec_o} <= {w_nxt_t, w_nxt_o};
        default: ;
      endcase
    end
  end

  // ---------------- overwrite pulse ----------------
  // Raised on the edge that enters COMMIT, so the shadow has already been
  // stable for at least the mode cycle. Held OW_CYCLES cycles, then one low
  // cycle before the counter releases the FSM to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ow     <= 1'b0;
      r_ow_cnt <= '0;
    end else if (r_state != ST_COMMIT && w_nxt == ST_COMMIT) begin
      r_ow     <= 1'b1;
      r_ow_cnt <= '0;
    end else if (r_state == ST_COMMIT) begin
      if (r_ow_cnt != OW_W'(OW_CYCLES)) r_ow_cnt <= r_ow_cnt + 1'b1;
      r_ow <= ((32'(r_ow_cnt) + 32'd1) < 32'(OW_CYCLES));
    end else begin
      r_ow     <= 1'b0;
      r_ow_cnt <= '0;
    end
  end

  // ---------------- blink ----------------
  // Any button activity on the field (including an inc+dec that cancels out)
  // or a field change restarts the phase so the digits stay solid while edited.
  assign w_blink_clr = !is_edit(w_nxt) || (w_nxt != r_state) || w_step_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (w_blink_clr) begin
      r_blink     <= 1'b0;
      r_blink_cnt <= '0;
    end else if (r_blink_cnt == BL_W'(BLINK_HALF - 1)) begin
      r_blink     <= ~r_blink;
      r_blink_cnt <= '0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign {set_hr_t, set_hr_o, set_min_t, set_min_o, set_sec_t, set_sec_o} = r_shadow;
  assign time_ow = r_ow;
  assign blink   = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl
//   Self-checking bench: a behavioural model holds the time as integer
//   hours/minutes/seconds and a phase number; outputs are compared every
//   negedge, plus literal checks at key points of directed sessions and a
//   randomized button/time stream.
module tb_time_set_ctrl;

  localparam int OW = 2;
  localparam int BH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_cancel = 1'b0;
  logic [3:0] cur_hr_t = 4'd0, cur_hr_o = 4'd0, cur_min_t = 4'd0;
  logic [3:0] cur_min_o = 4'd0, cur_sec_t = 4'd0, cur_sec_o = 4'd0;
  logic [3:0] set_hr_t, set_hr_o, set_min_t, set_min_o, set_sec_t, set_sec_o;
  logic       time_ow, set_active, blink;
  logic [1:0] field_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.OW_CYCLES(OW), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
    .cur_hr_t(cur_hr_t), .cur_hr_o(cur_hr_o), .cur_min_t(cur_min_t),
    .cur_min_o(cur_min_o), .cur_sec_t(cur_sec_t), .cur_sec_o(cur_sec_o),
    .set_hr_t(set_hr_t), .set_hr_o(set_hr_o), .set_min_t(set_min_t),
    .set_min_o(set_min_o), .set_sec_t(set_sec_t), .set_sec_o(set_sec_o),
    .time_ow(time_ow), .set_active(set_active), .field_sel(field_sel), .blink(blink)
  );

  // ---------------- behavioural model ----------------
  localparam int P_IDLE = 0, P_CAP = 1, P_HR = 2, P_MIN = 3, P_SEC = 4, P_COMMIT = 5;
  int m_ph = P_IDLE;
  int m_h = 0, m_m = 0, m_s = 0;
  int m_ns = 0, m_cc = 0, m_age = 0;
  logic [23:0] m_last = 24'd0;
  logic [23:0] m_cv;

  function automatic int dec_val(input logic [3:0] t, input logic [3:0] o, input int lim);
    int v;
    if (t > 4'd9 || o > 4'd9) return 0;
    v = int'(t) * 10 + int'(o);
    return (v < lim) ? v : 0;
  endfunction

  function automatic int wrap_step(input int v, input int lim, input bit up);
    return up ? (v + 1) % lim : (v + lim - 1) % lim;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_IDLE; m_h = 0; m_m = 0; m_s = 0;
      m_ns = 0; m_cc = 0; m_age = 0;
    end else begin
      m_cv = {cur_hr_t, cur_hr_o, cur_min_t, cur_min_o, cur_sec_t, cur_sec_o};
      case (m_ph)
        P_IDLE: if (btn_mode && !btn_cancel) begin m_ph = P_CAP; m_ns = 0; end
        P_CAP: begin
          if (btn_cancel) m_ph = P_IDLE;
          else if ((m_ns >= 1 && m_cv == m_last) || m_ns == 3) begin
            m_h = dec_val(cur_hr_t, cur_hr_o, 24);
            m_m = dec_val(cur_min_t, cur_min_o, 60);
            m_s = dec_val(cur_sec_t, cur_sec_o, 60);
            m_ph = P_HR; m_age = 0;
          end else begin
            m_last = m_cv; m_ns++;
          end
        end
        P_HR, P_MIN, P_SEC: begin
          if (btn_cancel) m_ph = P_IDLE;
          else if (btn_mode) begin m_ph = m_ph + 1; m_age = 0; m_cc = 0; end
          else begin
            if (btn_inc != btn_dec) begin
              if (m_ph == P_HR)       m_h = wrap_step(m_h, 24, btn_inc);
              else if (m_ph == P_MIN) m_m = wrap_step(m_m, 60, btn_inc);
              else                    m_s = wrap_step(m_s, 60, btn_inc);
            end
            if (btn_inc || btn_dec) m_age = 0;
            else m_age++;
          end
        end
        P_COMMIT: if (m_cc == OW) m_ph = P_IDLE; else m_cc++;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  function automatic logic [23:0] bcd6(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] dut_set();
    return {set_hr_t, set_hr_o, set_min_t, set_min_o, set_sec_t, set_sec_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle compare: every output, every cycle.
  always @(negedge clk) begin
    logic [28:0] e, a;
    logic [1:0] fs;
    logic bl, ow;
    fs = (m_ph >= P_HR && m_ph <= P_SEC) ? 2'(m_ph - 1) : 2'd0;
    bl = (m_ph >= P_HR && m_ph <= P_SEC) ? (((m_age / BH) % 2) == 1) : 1'b0;
    ow = (m_ph == P_COMMIT) && (m_cc < OW);
    e = {bcd6(m_h, m_m, m_s), ow, (m_ph != P_IDLE), fs, bl};
    a = {dut_set(), time_ow, set_active, field_sel, blink};
    chk("cycle_model", 32'(a), 32'(e));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i, input logic d, input logic c);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
    @(posedge clk); #1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
  endtask

  task automatic set_cur(input logic [23:0] v);
    {cur_hr_t, cur_hr_o, cur_min_t, cur_min_o, cur_sec_t, cur_sec_o} = v;
  endtask

  initial begin
    int owc;
    // reset state
    tick(3);
    chk("reset_set", 32'(dut_set()), 32'h0);
    chk("reset_flags", {28'd0, time_ow, set_active, field_sel}, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // 1: capture 12:34:56
    set_cur(24'h123456);
    press(1, 0, 0, 0);
    tick(2);
    chk("t1_set", 32'(dut_set()), 32'h123456);
    chk("t1_fs_act", {30'd0, set_active, field_sel == 2'd1}, 32'h3);
    tick(BH);
    chk("t1_blink", 32'(blink), 32'h1);

    // 2: wrap boundaries
    repeat (11) press(0, 1, 0, 0);
    chk("t2_hr23", 32'(dut_set()), 32'h233456);
    chk("t2_blink_solid", 32'(blink), 32'h0);
    press(0, 1, 0, 0);
    chk("t2_hr_inc_wrap", 32'(dut_set()), 32'h003456);
    press(0, 0, 1, 0);
    chk("t2_hr_dec_wrap", 32'(dut_set()), 32'h233456);
    press(1, 0, 0, 0);
    repeat (26) press(0, 1, 0, 0);
    chk("t2_min_wrap", 32'(dut_set()), 32'h230056);
    repeat (10) press(0, 1, 0, 0);
    chk("t2_min_carry", 32'(dut_set()), 32'h231056);
    press(1, 0, 0, 0);
    repeat (4) press(0, 1, 0, 0);
    chk("t2_sec00", 32'(dut_set()), 32'h231000);
    press(0, 0, 1, 0);
    chk("t2_sec_dec_wrap", 32'(dut_set()), 32'h231059);
    press(0, 0, 0, 1);
    chk("t2_cancel", {31'd0, set_active}, 32'h0);

    // 3: full session with commit
    press(1, 0, 0, 0);
    tick(2);
    press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    owc = 0;
    for (int i = 0; i < 6; i++) begin
      if (time_ow) owc++;
      chk("t3_set_stable", 32'(dut_set()), 32'h133456);
      tick(1);
    end
    chk("t3_ow_len", 32'(owc), 32'd2);
    chk("t3_idle", {31'd0, set_active}, 32'h0);

    // 4: cancel in EDIT_MIN
    press(1, 0, 0, 0);
    tick(2);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    chk("t4_idle", {31'd0, set_active}, 32'h0);
    chk("t4_set_kept", 32'(dut_set()), 32'h123556);

    // 5: simultaneous pulses
    press(1, 0, 0, 0);
    tick(2);
    press(0, 1, 1, 0);
    chk("t5_incdec", 32'(dut_set()), 32'h123456);
    press(1, 1, 0, 0);
    chk("t5_mode_inc_fs", 32'(field_sel), 32'd2);
    chk("t5_mode_inc_set", 32'(dut_set()), 32'h123456);
    press(1, 0, 0, 0);
    press(1, 0, 0, 1);
    chk("t5_cancel_mode", {30'd0, set_active, time_ow}, 32'h0);
    tick(3);

    // 6: reset during COMMIT, then invalid hour capture
    press(1, 0, 0, 0);
    tick(2);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("t6_ow_up", 32'(time_ow), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("t6_ow_async_drop", {30'd0, time_ow, set_active}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1);
    cur_hr_t = 4'd7; cur_hr_o = 4'hA;
    press(1, 0, 0, 0);
    tick(2);
    chk("t6_hr_clamp", 32'(dut_set()), 32'h003456);
    press(0, 0, 0, 1);

    // randomized stream
    for (int i = 0; i < 1500; i++) begin
      btn_mode   = ($urandom_range(0, 99) < 8);
      btn_inc    = ($urandom_range(0, 99) < 25);
      btn_dec    = ($urandom_range(0, 99) < 20);
      btn_cancel = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 30) begin
        cur_hr_t  = 4'($urandom_range(0, 2));
        cur_hr_o  = 4'($urandom_range(0, 9));
        cur_min_t = 4'($urandom_range(0, 5));
        cur_min_o = 4'($urandom_range(0, 9));
        cur_sec_t = 4'($urandom_range(0, 5));
        cur_sec_o = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 9) == 0) cur_min_t = 4'($urandom_range(6, 15));
        if ($urandom_range(0, 9) == 0) cur_hr_o  = 4'($urandom_range(4, 15));
      end
      tick(1);
    end
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
